// File: rtl/data_mem_responder_pkg.sv
// Shared constants for the data-memory responder: bus widths, transfer size codes,
// FSM state encodings and the size-to-lane mask helper.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef MEM_TRANSFER_WIDTH
`define MEM_TRANSFER_WIDTH 2
`endif

package data_mem_responder_pkg;

  localparam logic [1:0] MEM_TRANSFER_BYTE = 2'b00;
  localparam logic [1:0] MEM_TRANSFER_HALF = 2'b01;
  localparam logic [1:0] MEM_TRANSFER_WORD = 2'b10;

  typedef enum logic [1:0] {
    DMEM_IDLE = 2'd0,
    DMEM_WAIT = 2'd1,
    DMEM_RESP = 2'd2
  } dmem_state_e;

  // Reserved code 11 falls through to a full-word mask.
  function automatic logic [3:0] size_mask(input logic [1:0] transfer);
    case (transfer)
      MEM_TRANSFER_BYTE: size_mask = 4'b0001;
      MEM_TRANSFER_HALF: size_mask = 4'b0011;
      default:           size_mask = 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational byte-lane steering: byte enables, shifted store data, aligned/masked
// load data and the misalignment flag for one access.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef MEM_TRANSFER_WIDTH
`define MEM_TRANSFER_WIDTH 2
`endif

module dmem_lane_align
  import data_mem_responder_pkg::*;
(
  input  logic [`MEM_TRANSFER_WIDTH-1:0] transfer_i,
  input  logic [1:0]                     offset_i,
  input  logic [`DATA_WIDTH-1:0]         wdata_i,
  input  logic [`DATA_WIDTH-1:0]         rword_i,
  output logic [3:0]                     be_o,
  output logic [`DATA_WIDTH-1:0]         wdata_o,
  output logic [`DATA_WIDTH-1:0]         rdata_o,
  output logic                           misaligned_o
);

  logic [3:0]             base;
  logic [4:0]             shamt;
  logic [`DATA_WIDTH-1:0] rmask;

  always_comb begin
    base    = size_mask(transfer_i);
    // Lanes shifted past byte 3 are simply dropped by the 4-bit truncation.
    be_o    = base << offset_i;
    shamt   = {offset_i, 3'b000};
    wdata_o = wdata_i << shamt;
    rmask   = {{8{base[3]}}, {8{base[2]}}, {8{base[1]}}, {8{base[0]}}};
    rdata_o = (rword_i >> shamt) & rmask;
    misaligned_o = ((transfer_i == MEM_TRANSFER_HALF) && offset_i[0])
                || ((transfer_i == MEM_TRANSFER_WORD) && (offset_i != 2'b00))
                || (transfer_i == 2'b11);
  end

endmodule

// File: rtl/data_mem_responder.sv
// Single-port data-memory responder with req/gnt handshake and WAIT_CYCLES wait states.
// Define DMEM_ALIGN_ERR_EN to compile in misalignment error responses.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef MEM_TRANSFER_WIDTH
`define MEM_TRANSFER_WIDTH 2
`endif

module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 0
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           data_req_i,
  input  logic                           data_we_i,
  input  logic [`DATA_WIDTH-1:0]         data_addr_i,
  input  logic [`DATA_WIDTH-1:0]         data_wdata_i,
  input  logic [`MEM_TRANSFER_WIDTH-1:0] data_transfer_i,
  output logic                           data_gnt_o,
  output logic                           data_rvalid_o,
  output logic [`DATA_WIDTH-1:0]         data_rdata_o,
  output logic                           data_err_o,
  output logic                           busy_o
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] CNT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  dmem_state_e state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        gnt;

  logic                           we_q;
  logic [AW+1:0]                  addr_q;
  logic [`DATA_WIDTH-1:0]         wdata_q;
  logic [`MEM_TRANSFER_WIDTH-1:0] xfer_q;

  logic                           acc_en, acc_we;
  logic [AW+1:0]                  acc_addr;
  logic [`DATA_WIDTH-1:0]         acc_wdata;
  logic [`MEM_TRANSFER_WIDTH-1:0] acc_xfer;

  logic [3:0]             be;
  logic [`DATA_WIDTH-1:0] wdata_sh, rdata_al, rword;
  logic                   misaligned, err_access;

  logic [`DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                   err_q, err_d;
  logic [`DATA_WIDTH-1:0] mem_q [DEPTH_WORDS];

  logic unused_addr;
  assign unused_addr = ^{data_addr_i[`DATA_WIDTH-1:AW+2], misaligned};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= DMEM_IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      DMEM_WAIT: begin
        if (cnt_q == 4'd0) state_d = DMEM_RESP;
        else               cnt_d   = cnt_q - 4'd1;
      end
      default: begin
        if (gnt) begin
          if (WAIT_CYCLES > 0) begin
            state_d = DMEM_WAIT;
            cnt_d   = CNT_LOAD;
          end else begin
            state_d = DMEM_RESP;
          end
        end else begin
          state_d = DMEM_IDLE;
        end
      end
    endcase
  end

  always_comb begin
    gnt           = data_req_i & ((state_q == DMEM_IDLE) | (state_q == DMEM_RESP));
    data_gnt_o    = gnt;
    data_rvalid_o = (state_q == DMEM_RESP);
    busy_o        = (state_q == DMEM_WAIT);
    data_rdata_o  = rdata_q;
    data_err_o    = err_q;
  end

  always_ff @(posedge clk) begin
    if (gnt) begin
      we_q    <= data_we_i;
      addr_q  <= data_addr_i[AW+1:0];
      wdata_q <= data_wdata_i;
      xfer_q  <= data_transfer_i;
    end
  end

  // With zero wait states the access happens on the grant edge, before the
  // request registers are loaded, so the live inputs must be used.
  always_comb begin
    acc_en = rst_n && (state_d == DMEM_RESP);
    if (state_q == DMEM_WAIT) begin
      acc_we    = we_q;
      acc_addr  = addr_q;
      acc_wdata = wdata_q;
      acc_xfer  = xfer_q;
    end else begin
      acc_we    = data_we_i;
      acc_addr  = data_addr_i[AW+1:0];
      acc_wdata = data_wdata_i;
      acc_xfer  = data_transfer_i;
    end
  end

  assign rword = mem_q[acc_addr[AW+1:2]];

  dmem_lane_align u_lane_align (
    .transfer_i   (acc_xfer),
    .offset_i     (acc_addr[1:0]),
    .wdata_i      (acc_wdata),
    .rword_i      (rword),
    .be_o         (be),
    .wdata_o      (wdata_sh),
    .rdata_o      (rdata_al),
    .misaligned_o (misaligned)
  );

  always_comb begin
`ifdef DMEM_ALIGN_ERR_EN
    err_access = misaligned;
`else
    err_access = 1'b0;
`endif
    rdata_d = (acc_we || err_access) ? '0 : rdata_al;
    err_d   = err_access;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else if (acc_en) begin
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (acc_en && acc_we && !err_access) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem_q[acc_addr[AW+1:2]][8*i +: 8] <= wdata_sh[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: one zero-wait and one three-wait instance.
module tb_data_mem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        req   [2];
  logic        we    [2];
  logic [31:0] addr  [2];
  logic [31:0] wdata [2];
  logic [1:0]  xfer  [2];
  logic        gnt   [2];
  logic        rvalid[2];
  logic [31:0] rdata [2];
  logic        err   [2];
  logic        busy  [2];

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          due;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  always @(posedge clk) cyc <= cyc + 1;

  data_mem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .data_req_i(req[0]), .data_we_i(we[0]),
    .data_addr_i(addr[0]), .data_wdata_i(wdata[0]), .data_transfer_i(xfer[0]),
    .data_gnt_o(gnt[0]), .data_rvalid_o(rvalid[0]), .data_rdata_o(rdata[0]),
    .data_err_o(err[0]), .busy_o(busy[0])
  );

  data_mem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(3)) dut1 (
    .clk(clk), .rst_n(rst_n), .data_req_i(req[1]), .data_we_i(we[1]),
    .data_addr_i(addr[1]), .data_wdata_i(wdata[1]), .data_transfer_i(xfer[1]),
    .data_gnt_o(gnt[1]), .data_rvalid_o(rvalid[1]), .data_rdata_o(rdata[1]),
    .data_err_o(err[1]), .busy_o(busy[1])
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n === 1'b1 && rvalid[0] === 1'b1) begin
      if (q0.size() == 0) begin
        check("d0_unexpected_rvalid", 32'd1, 32'd0);
      end else begin
        e = q0.pop_front();
        check("d0_rdata", rdata[0], e.rdata);
        check("d0_err", {31'd0, err[0]}, {31'd0, e.err});
        check("d0_latency_cycle", cyc, e.due);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst_n === 1'b1 && rvalid[1] === 1'b1) begin
      if (q1.size() == 0) begin
        check("d1_unexpected_rvalid", 32'd1, 32'd0);
      end else begin
        e = q1.pop_front();
        check("d1_rdata", rdata[1], e.rdata);
        check("d1_err", {31'd0, err[1]}, {31'd0, e.err});
        check("d1_latency_cycle", cyc, e.due);
      end
    end
  end

  // Presents a request, waits (bounded) for grant, queues the expected response,
  // and returns #1 after the grant edge with the request still asserted.
  task automatic issue(input int d, input logic w, input logic [31:0] a,
                       input logic [31:0] wd, input logic [1:0] x,
                       input logic [31:0] er, input logic ee, input bit track);
    int   n;
    bit   granted;
    exp_t e;
    req[d] = 1'b1; we[d] = w; addr[d] = a; wdata[d] = wd; xfer[d] = x;
    n = 0;
    granted = 1'b0;
    while (!granted && n < 50) begin
      @(negedge clk);
      if (gnt[d] === 1'b1) granted = 1'b1;
      else n++;
    end
    if (!granted) begin
      check("grant_timeout", 32'd0, 32'd1);
    end else if (track) begin
      e.rdata = er;
      e.err   = ee;
      e.due   = cyc + 1 + ((d == 0) ? 0 : 3);
      if (d == 0) q0.push_back(e);
      else        q1.push_back(e);
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input int d, input int k);
    req[d] = 1'b0;
    repeat (k) begin
      @(posedge clk); #1;
    end
  endtask

  logic [31:0] half21_word, half21_rdata, x11_rdata, half23_rdata;
  logic        misalign_err;

  initial begin
    int n;
`ifdef DMEM_ALIGN_ERR_EN
    misalign_err = 1'b1;
    half21_word  = 32'h55667788;
    half21_rdata = 32'h0;
    x11_rdata    = 32'h0;
    half23_rdata = 32'h0;
`else
    misalign_err = 1'b0;
    half21_word  = 32'h55BEEF88;
    half21_rdata = 32'h0;
    x11_rdata    = 32'h55BEEF88;
    half23_rdata = 32'h00000055;
`endif
    for (int i = 0; i < 2; i++) begin
      req[i] = 1'b0; we[i] = 1'b0; addr[i] = '0; wdata[i] = '0; xfer[i] = 2'b10;
    end
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_rvalid", {31'd0, rvalid[0]}, 32'd0);
    check("reset_rdata", rdata[0], 32'd0);
    check("reset_err", {31'd0, err[0]}, 32'd0);
    check("reset_busy", {31'd0, busy[1]}, 32'd0);
    check("reset_gnt", {31'd0, gnt[0]}, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // Zero-wait instance: word store/load back-to-back.
    issue(0, 1'b1, 32'h10, 32'hDEADBEEF, 2'b10, 32'h0, 1'b0, 1'b1);
    issue(0, 1'b0, 32'h10, 32'h0, 2'b10, 32'hDEADBEEF, 1'b0, 1'b1);
    // Byte store into an existing word, then word/byte/half loads.
    issue(0, 1'b1, 32'h10, 32'h11223344, 2'b10, 32'h0, 1'b0, 1'b1);
    issue(0, 1'b1, 32'h13, 32'h000000AA, 2'b00, 32'h0, 1'b0, 1'b1);
    issue(0, 1'b0, 32'h10, 32'h0, 2'b10, 32'hAA223344, 1'b0, 1'b1);
    issue(0, 1'b0, 32'h13, 32'h0, 2'b00, 32'h000000AA, 1'b0, 1'b1);
    issue(0, 1'b0, 32'h12, 32'h0, 2'b01, 32'h0000AA22, 1'b0, 1'b1);
    issue(0, 1'b0, 32'h10, 32'h0, 2'b00, 32'h00000044, 1'b0, 1'b1);
    idle(0, 2);
    // Misaligned half store, reserved size code, half at lane 3.
    issue(0, 1'b1, 32'h20, 32'h55667788, 2'b10, 32'h0, 1'b0, 1'b1);
    issue(0, 1'b1, 32'h21, 32'h0000BEEF, 2'b01, half21_rdata, misalign_err, 1'b1);
    issue(0, 1'b0, 32'h20, 32'h0, 2'b10, half21_word, 1'b0, 1'b1);
    issue(0, 1'b0, 32'h20, 32'h0, 2'b11, x11_rdata, misalign_err, 1'b1);
    issue(0, 1'b0, 32'h23, 32'h0, 2'b01, half23_rdata, misalign_err, 1'b1);
    // Address wrap: 0x1000 aliases word 0.
    issue(0, 1'b1, 32'h1000, 32'hCAFEF00D, 2'b10, 32'h0, 1'b0, 1'b1);
    issue(0, 1'b0, 32'h0000, 32'h0, 2'b10, 32'hCAFEF00D, 1'b0, 1'b1);
    idle(0, 3);

    // Three-wait instance: hold the request through WAIT.
    issue(1, 1'b1, 32'h40, 32'h0BADF00D, 2'b10, 32'h0, 1'b0, 1'b1);
    n = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("d1_no_gnt_while_busy", {31'd0, gnt[1]}, 32'd0);
      if (busy[1] === 1'b1) n++;
      @(posedge clk); #1;
    end
    req[1] = 1'b0;
    check("d1_busy_cycles", n, 32'd3);
    issue(1, 1'b0, 32'h40, 32'h0, 2'b10, 32'h0BADF00D, 1'b0, 1'b1);
    idle(1, 6);

    // Reset during the WAIT of a store: outputs clear, storage untouched.
    issue(1, 1'b1, 32'h40, 32'h12345678, 2'b10, 32'h0, 1'b0, 1'b0);
    req[1] = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("abort_rvalid", {31'd0, rvalid[1]}, 32'd0);
    check("abort_busy", {31'd0, busy[1]}, 32'd0);
    check("abort_rdata", rdata[1], 32'd0);
    check("abort_err", {31'd0, err[1]}, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    issue(1, 1'b0, 32'h40, 32'h0, 2'b10, 32'h0BADF00D, 1'b0, 1'b1);
    idle(1, 1);

    n = 0;
    while ((q0.size() != 0 || q1.size() != 0) && n < 30) begin
      @(posedge clk);
      n++;
    end
    #1;
    check("scoreboard_drained", q0.size() + q1.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
